// File: rtl/rop_csr_ctrl.sv
// ROP configuration controller: CSR writes go to shadow registers, and a commit
// drains in-flight fragments before copying the shadow set to the active set.
module rop_csr_ctrl #(
    parameter int  MAX_INFLIGHT = 16,
    localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         csr_wr_valid,
    input  logic [3:0]   csr_wr_addr,
    input  logic [31:0]  csr_wr_data,
    input  logic [3:0]   csr_rd_addr,
    output logic [31:0]  csr_rd_data,
    input  logic         commit_valid,
    output logic         commit_ready,
    input  logic         frag_enq,
    output logic         frag_admit,
    input  logic         frag_deq,
    output logic [194:0] rop_csrs,
    output logic         busy
);

    localparam int NUM_FIELDS = 15;
    localparam int CFG_W      = 195;

    // Field layout of rop_csrs_t, first struct member in the MSBs.
    localparam int FLD_W   [NUM_FIELDS] = '{32, 32, 32, 32, 3, 3, 3, 3, 3, 4, 4, 4, 4, 32, 4};
    localparam int FLD_LSB [NUM_FIELDS] = '{163, 131, 99, 67, 64, 61, 58, 55, 52, 48, 44, 40, 36, 4, 0};

    // Index 15 has a zero mask and zero reset value so it always reads back 0.
    localparam logic [31:0] FLD_MASK [16] = '{
        32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'h7, 32'h7, 32'h7, 32'h7, 32'h7,
        32'hF, 32'hF, 32'hF, 32'hF,
        32'hFFFF_FFFF, 32'hF, 32'h0
    };
    localparam logic [31:0] FLD_RST [16] = '{
        32'h0, 32'h0, 32'h0, 32'h0,
        32'h7, 32'h7,
        32'h0, 32'h0, 32'h0,
        32'h1, 32'h0, 32'h1, 32'h0,
        32'h0, 32'h3, 32'h0
    };

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRAIN  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [31:0]        r_shadow [16];
    logic [CFG_W-1:0]   r_active;
    logic               r_commit_ready;
    logic               r_busy;

    logic [CFG_W-1:0]   w_shadow_cfg;
    logic [CFG_W-1:0]   w_reset_cfg;
    logic               w_inc;
    logic               w_dec;

    generate
        for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_pack
            assign w_shadow_cfg[FLD_LSB[gi] +: FLD_W[gi]] = r_shadow[gi][FLD_W[gi]-1:0];
            assign w_reset_cfg[FLD_LSB[gi] +: FLD_W[gi]]  = FLD_RST[gi][FLD_W[gi]-1:0];
        end
    endgenerate

    // Shadow writes are accepted in every state, including the COMMIT cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                r_shadow[i] <= FLD_RST[i];
            end
        end else if (csr_wr_valid) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                if (csr_wr_addr == 4'(i)) begin
                    r_shadow[i] <= csr_wr_data & FLD_MASK[i];
                end
            end
        end
    end

    assign csr_rd_data = r_shadow[csr_rd_addr];

    assign frag_admit = (r_state == S_IDLE) && (r_count < CNT_W'(MAX_INFLIGHT));
    assign w_inc      = frag_enq && frag_admit;
    // A retire against an empty pipe is ignored so the count cannot wrap.
    assign w_dec      = frag_deq && (r_count != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (w_inc && !w_dec) begin
            r_count <= r_count + CNT_W'(1);
        end else if (!w_inc && w_dec) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_active       <= w_reset_cfg;
            r_commit_ready <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_commit_ready <= 1'b0;
                    if (commit_valid) begin
                        r_state <= S_DRAIN;
                        r_busy  <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_count == '0) begin
                        r_state        <= S_COMMIT;
                        r_commit_ready <= 1'b1;
                    end
                end
                S_COMMIT: begin
                    r_active       <= w_shadow_cfg;
                    r_state        <= S_IDLE;
                    r_commit_ready <= 1'b0;
                    r_busy         <= 1'b0;
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_commit_ready <= 1'b0;
                    r_busy         <= 1'b0;
                end
            endcase
        end
    end

    assign rop_csrs     = r_active;
    assign commit_ready = r_commit_ready;
    assign busy         = r_busy;

    assert property (@(posedge clk) disable iff (!reset_n) !(frag_deq && (r_count == '0)));

endmodule

// File: tb/tb_rop_csr_ctrl.sv
// Directed bench for rop_csr_ctrl; committed configurations go through an
// expected-value queue that is popped when the commit lands.
module tb_rop_csr_ctrl;

    localparam logic [194:0] RST_CFG = {128'd0, 3'd7, 3'd7, 9'd0,
                                        4'd1, 4'd0, 4'd1, 4'd0, 32'd0, 4'd3};

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         csr_wr_valid = 1'b0;
    logic [3:0]   csr_wr_addr = '0;
    logic [31:0]  csr_wr_data = '0;
    logic [3:0]   csr_rd_addr = '0;
    logic [31:0]  csr_rd_data;
    logic         commit_valid = 1'b0;
    logic         commit_ready;
    logic         frag_enq = 1'b0;
    logic         frag_admit;
    logic         frag_deq = 1'b0;
    logic [194:0] rop_csrs;
    logic         busy;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [31:0]  m_shadow [16];
    logic [194:0] exp_q [$];

    rop_csr_ctrl #(.MAX_INFLIGHT(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .csr_wr_valid(csr_wr_valid), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
        .csr_rd_addr(csr_rd_addr), .csr_rd_data(csr_rd_data),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .frag_enq(frag_enq), .frag_admit(frag_admit), .frag_deq(frag_deq),
        .rop_csrs(rop_csrs), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [194:0] obs, input logic [194:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_shadow = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h7, 32'h7, 32'h0, 32'h0,
                     32'h0, 32'h1, 32'h0, 32'h1, 32'h0, 32'h0, 32'h3, 32'h0};
    endtask

    function automatic logic [31:0] fld_mask(input logic [3:0] a);
        if (a <= 4'd3 || a == 4'd13) return 32'hFFFF_FFFF;
        if (a <= 4'd8)               return 32'h7;
        if (a == 4'd15)              return 32'h0;
        return 32'hF;
    endfunction

    function automatic logic [194:0] model_cfg();
        return {m_shadow[0], m_shadow[1], m_shadow[2], m_shadow[3],
                m_shadow[4][2:0], m_shadow[5][2:0], m_shadow[6][2:0],
                m_shadow[7][2:0], m_shadow[8][2:0],
                m_shadow[9][3:0], m_shadow[10][3:0], m_shadow[11][3:0], m_shadow[12][3:0],
                m_shadow[13], m_shadow[14][3:0]};
    endfunction

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        csr_wr_valid = 1'b1;
        csr_wr_addr  = a;
        csr_wr_data  = d;
        m_shadow[a]  = d & fld_mask(a);
        tick();
        csr_wr_valid = 1'b0;
        $display("write idx %0d data %h", a, d);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        csr_rd_addr = a;
        #1;
        chk(tag, csr_rd_data, exp);
        $display("read idx %0d data %h", a, csr_rd_data);
    endtask

    task automatic do_commit(input string tag);
        logic seen;
        exp_q.push_back(model_cfg());
        commit_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (commit_ready) seen = 1'b1;
        end
        chk({tag, "_ready"}, seen, 1'b1);
        commit_valid = 1'b0;
        tick();
        chk({tag, "_cfg"}, rop_csrs, exp_q.pop_front());
        $display("commit %s cfg %h", tag, rop_csrs);
    endtask

    initial begin
        int bad;
        model_reset();

        // Reset state
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        chk("rst_cfg", rop_csrs, RST_CFG);
        chk("rst_admit", frag_admit, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", commit_ready, 1'b0);
        rd_chk("rst_rd_zfunc", 4'd4, 32'h7);

        // Shadow writes with truncation, unmapped index, no effect on active
        wr(4'd13, 32'hFF00_FF00);
        wr(4'd14, 32'h0000_001F);
        wr(4'd15, 32'hDEAD_BEEF);
        rd_chk("rd_blend_const", 4'd13, 32'hFF00_FF00);
        rd_chk("rd_logic_op", 4'd14, 32'h0000_000F);
        rd_chk("rd_unmapped", 4'd15, 32'h0);
        chk("cfg_before_commit", rop_csrs, RST_CFG);

        // Commit with empty pipe: DRAIN, COMMIT, then new config visible
        wr(4'd0, 32'h0000_1000);
        exp_q.push_back(model_cfg());
        commit_valid = 1'b1;
        tick();
        #1;
        chk("c1_drain_admit", frag_admit, 1'b0);
        chk("c1_drain_busy", busy, 1'b1);
        chk("c1_drain_ready", commit_ready, 1'b0);
        tick();
        chk("c1_commit_ready", commit_ready, 1'b1);
        chk("c1_commit_cfg_old", rop_csrs, RST_CFG);
        commit_valid = 1'b0;
        tick();
        chk("c1_cfg", rop_csrs, exp_q.pop_front());
        chk("c1_ready_drop", commit_ready, 1'b0);
        chk("c1_busy_drop", busy, 1'b0);
        $display("commit c1 cfg %h", rop_csrs);

        // Commit waits for three in-flight fragments to drain
        frag_enq = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (frag_admit !== 1'b1) bad++;
            tick();
        end
        frag_enq = 1'b0;
        chk("c2_admit3", bad, 0);
        wr(4'd1, 32'h0000_0040);
        exp_q.push_back(model_cfg());
        commit_valid = 1'b1;
        tick();
        tick();
        #1;
        chk("c2_drain_admit", frag_admit, 1'b0);
        chk("c2_drain_ready", commit_ready, 1'b0);
        frag_deq = 1'b1;
        tick();
        frag_enq = 1'b1;
        #1;
        chk("c2_blocked_enq", frag_admit, 1'b0);
        tick();
        frag_enq = 1'b0;
        tick();
        frag_deq = 1'b0;
        chk("c2_zero_still_drain", commit_ready, 1'b0);
        chk("c2_zero_busy", busy, 1'b1);
        tick();
        chk("c2_commit_ready", commit_ready, 1'b1);
        commit_valid = 1'b0;
        tick();
        chk("c2_cfg", rop_csrs, exp_q.pop_front());
        $display("commit c2 cfg %h", rop_csrs);

        // Fill to MAX_INFLIGHT, then a single retire reopens admission
        frag_enq = 1'b1;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (frag_admit !== 1'b1) bad++;
            tick();
        end
        chk("fill_admit16", bad, 0);
        #1;
        chk("full_admit", frag_admit, 1'b0);
        tick();
        chk("full_admit_hold", frag_admit, 1'b0);
        frag_enq = 1'b0;
        frag_deq = 1'b1;
        tick();
        frag_deq = 1'b0;
        #1;
        chk("after_deq_admit", frag_admit, 1'b1);
        frag_deq = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        frag_deq = 1'b0;

        // Write during the COMMIT cycle only reaches the next commit
        exp_q.push_back(model_cfg());
        commit_valid = 1'b1;
        tick();
        tick();
        chk("c3_commit_ready", commit_ready, 1'b1);
        commit_valid = 1'b0;
        csr_wr_valid = 1'b1;
        csr_wr_addr  = 4'd4;
        csr_wr_data  = 32'h0000_0002;
        m_shadow[4]  = 32'h2;
        tick();
        csr_wr_valid = 1'b0;
        chk("c3_cfg_old_zfunc", rop_csrs, exp_q.pop_front());
        rd_chk("c3_rd_new_zfunc", 4'd4, 32'h2);
        do_commit("c4");

        // Held commit_valid restarts a commit right after COMMIT
        exp_q.push_back(model_cfg());
        commit_valid = 1'b1;
        tick();
        tick();
        chk("c5_commit_ready", commit_ready, 1'b1);
        tick();
        chk("c5_cfg", rop_csrs, exp_q.pop_front());
        chk("c5_idle_busy", busy, 1'b0);
        tick();
        chk("c5_restart_busy", busy, 1'b1);
        commit_valid = 1'b0;

        // Asynchronous reset mid-DRAIN aborts the commit
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_cfg", rop_csrs, RST_CFG);
        chk("arst_ready", commit_ready, 1'b0);
        rd_chk("arst_rd_zbuf", 4'd0, 32'h0);
        tick();
        chk("arst_hold_ready", commit_ready, 1'b0);
        reset_n = 1'b1;
        model_reset();
        tick();
        tick();
        chk("arst_after_cfg", rop_csrs, RST_CFG);
        chk("arst_after_admit", frag_admit, 1'b1);
        rd_chk("arst_rd_logic_op", 4'd14, 32'h3);
        chk("exp_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
